ctrl_bus_rtc: RTL and testbench

- Bus-cycle engine that services the Inicio_Escritura / Inicio_Lectura requests from the general control FSM.
- Generates one complete transaction on the RTC chip's multiplexed address/data bus (Intel-style: cs_n, rd_n, wr_n, a_d select, 8-bit AD).
- A transaction is an address phase followed by a data phase.
- Captures read data and reports completion with a one-cycle fin pulse.

---
 rtl/ctrl_bus_rtc_pkg.sv | 35 +++
 rtl/ctrl_bus_rtc_if.sv | 23 ++
 rtl/ctrl_bus_rtc_contador_fase.sv | 30 +++
 rtl/ctrl_bus_rtc.sv | 160 ++++++++++++++++
 tb/tb_ctrl_bus_rtc.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_bus_rtc_pkg.sv
// Shared definitions for the RTC bus-cycle engine and the general control FSM.
// Holds the FSM state encoding, default phase timings and RTC register map.
package rtc_pkg;

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        DIR      = 3'd1,
        DIR_ESP  = 3'd2,
        DATO     = 3'd3,
        DATO_ESP = 3'd4,
        FIN      = 3'd5
    } estado_t;

    localparam int T_PULSO_DEF  = 4;
    localparam int T_ESPERA_DEF = 2;

    localparam logic [7:0] RTC_REG_CONTROL  = 8'h02;
    localparam logic [7:0] RTC_REG_SEGUNDOS = 8'h21;
    localparam logic [7:0] RTC_REG_MINUTOS  = 8'h22;
    localparam logic [7:0] RTC_REG_HORAS    = 8'h23;
    localparam logic [7:0] RTC_REG_DIA      = 8'h24;
    localparam logic [7:0] RTC_REG_MES      = 8'h25;
    localparam logic [7:0] RTC_REG_ANIO     = 8'h26;
    localparam logic [7:0] RTC_CMD_TRANSF   = 8'hF0;

    // Counter preload for a phase: the counter runs len-1 .. 0.
    function automatic logic [3:0] largo_fase(estado_t e, int tp, int te);
        case (e)
            DIR, DATO:         return 4'(tp - 1);
            DIR_ESP, DATO_ESP: return 4'(te - 1);
            default:           return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_bus_rtc_if.sv
// Multiplexed address/data bus to the RTC chip (Intel-style strobes).
// master = bus-cycle engine, slave = RTC pad side / bench model.
interface ctrl_bus_rtc_if #(
    parameter int ANCHO = 8
) ();
    logic [ANCHO-1:0] ad_in;
    logic [ANCHO-1:0] ad_out;
    logic             ad_oe;
    logic             cs_n;
    logic             rd_n;
    logic             wr_n;
    logic             a_d;

    modport master (
        input  ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );

    modport slave (
        output ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );
endinterface

// File: rtl/ctrl_bus_rtc_contador_fase.sv
// Loadable 4-bit phase down-counter; holds at zero and flags it.
// Load takes priority over counting.
module contador_fase (
    input  logic       CLK,
    input  logic       reset,
    input  logic       carga_i,
    input  logic [3:0] valor_i,
    output logic       cero_o
);
    logic [3:0] cuenta_q, cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (carga_i) begin
            cuenta_d = valor_i;
        end else if (cuenta_q != 4'd0) begin
            cuenta_d = cuenta_q - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cuenta_q <= 4'd0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cero_o = (cuenta_q == 4'd0);
endmodule

// File: rtl/ctrl_bus_rtc.sv
// Runs one address+data cycle on the RTC bus per accepted request, fin pulse on completion.
// Requests are only sampled while idle; anything arriving while ocupado is dropped.
module ctrl_bus_rtc
    import rtc_pkg::*;
#(
    parameter int T_PULSO  = T_PULSO_DEF,
    parameter int T_ESPERA = T_ESPERA_DEF,
    parameter int ANCHO    = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             Inicio_Escritura,
    input  logic             Inicio_Lectura,
    input  logic [ANCHO-1:0] direccion,
    input  logic [ANCHO-1:0] dato_escribir,
    output logic [ANCHO-1:0] dato_leido,
    output logic             ocupado,
    output logic             fin,
    ctrl_bus_rtc_if.master   bus
);
    estado_t          estado_q, estado_d;
    logic             es_escritura_q, es_escritura_d;
    logic [ANCHO-1:0] dir_q, dir_d;
    logic [ANCHO-1:0] dat_q, dat_d;
    logic             cero;
    logic             carga;
    logic [3:0]       valor_carga;

    logic [ANCHO-1:0] ad_out_q, ad_out_d;
    logic [ANCHO-1:0] leido_q, leido_d;
    logic             ad_oe_q, ad_oe_d;
    logic             cs_n_q, cs_n_d;
    logic             rd_n_q, rd_n_d;
    logic             wr_n_q, wr_n_d;
    logic             a_d_q, a_d_d;
    logic             ocupado_q, ocupado_d;
    logic             fin_q, fin_d;

    contador_fase u_contador (
        .CLK     (CLK),
        .reset   (reset),
        .carga_i (carga),
        .valor_i (valor_carga),
        .cero_o  (cero)
    );

    always_comb begin
        estado_d       = estado_q;
        es_escritura_d = es_escritura_q;
        dir_d          = dir_q;
        dat_d          = dat_q;
        case (estado_q)
            REPOSO: begin
                if (Inicio_Escritura || Inicio_Lectura) begin
                    es_escritura_d = Inicio_Escritura;
                    dir_d          = direccion;
                    dat_d          = dato_escribir;
                    estado_d       = DIR;
                end
            end
            DIR:      if (cero) estado_d = DIR_ESP;
            DIR_ESP:  if (cero) estado_d = DATO;
            DATO:     if (cero) estado_d = DATO_ESP;
            DATO_ESP: if (cero) estado_d = FIN;
            FIN:      estado_d = REPOSO;
            default:  estado_d = REPOSO;
        endcase
    end

    assign carga       = (estado_d != estado_q);
    assign valor_carga = largo_fase(estado_d, T_PULSO, T_ESPERA);

    // Outputs are decoded from the upcoming state so the registered pins line up with it.
    always_comb begin
        cs_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        a_d_d     = 1'b0;
        ad_oe_d   = 1'b0;
        ad_out_d  = ad_out_q;
        fin_d     = 1'b0;
        ocupado_d = (estado_d != REPOSO);
        leido_d   = leido_q;
        case (estado_d)
            DIR: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = dir_d;
            end
            DIR_ESP: begin
                ad_oe_d = (estado_q == DIR);
            end
            DATO: begin
                cs_n_d = 1'b0;
                a_d_d  = 1'b1;
                if (es_escritura_d) begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = dat_d;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            DATO_ESP: begin
                a_d_d   = 1'b1;
                ad_oe_d = es_escritura_d && (estado_q == DATO);
            end
            FIN: begin
                fin_d = 1'b1;
            end
            default: ;
        endcase
        if (estado_q == DATO && cero && !es_escritura_q) begin
            leido_d = bus.ad_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            estado_q       <= REPOSO;
            es_escritura_q <= 1'b0;
            dir_q          <= '0;
            dat_q          <= '0;
            ad_out_q       <= '0;
            leido_q        <= '0;
            ad_oe_q        <= 1'b0;
            cs_n_q         <= 1'b1;
            rd_n_q         <= 1'b1;
            wr_n_q         <= 1'b1;
            a_d_q          <= 1'b0;
            ocupado_q      <= 1'b0;
            fin_q          <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            es_escritura_q <= es_escritura_d;
            dir_q          <= dir_d;
            dat_q          <= dat_d;
            ad_out_q       <= ad_out_d;
            leido_q        <= leido_d;
            ad_oe_q        <= ad_oe_d;
            cs_n_q         <= cs_n_d;
            rd_n_q         <= rd_n_d;
            wr_n_q         <= wr_n_d;
            a_d_q          <= a_d_d;
            ocupado_q      <= ocupado_d;
            fin_q          <= fin_d;
        end
    end

    assign bus.ad_out = ad_out_q;
    assign bus.ad_oe  = ad_oe_q;
    assign bus.cs_n   = cs_n_q;
    assign bus.rd_n   = rd_n_q;
    assign bus.wr_n   = wr_n_q;
    assign bus.a_d    = a_d_q;
    assign dato_leido = leido_q;
    assign ocupado    = ocupado_q;
    assign fin        = fin_q;
endmodule

// File: tb/tb_ctrl_bus_rtc.sv
// Bench for ctrl_bus_rtc: scoreboard of expected transactions checked at each fin.
// A negedge bus monitor measures every transaction's phases and strobe rules.
module tb_ctrl_bus_rtc;
    import rtc_pkg::*;

    localparam int TP = 4;
    localparam int TE = 2;

    logic       CLK = 1'b0;
    logic       reset;
    logic       Inicio_Escritura, Inicio_Lectura;
    logic [7:0] direccion, dato_escribir, dato_leido;
    logic       ocupado, fin;
    logic [7:0] rd_val;

    ctrl_bus_rtc_if #(.ANCHO(8)) bus ();

    ctrl_bus_rtc #(.T_PULSO(TP), .T_ESPERA(TE), .ANCHO(8)) dut (
        .CLK              (CLK),
        .reset            (reset),
        .Inicio_Escritura (Inicio_Escritura),
        .Inicio_Lectura   (Inicio_Lectura),
        .direccion        (direccion),
        .dato_escribir    (dato_escribir),
        .dato_leido       (dato_leido),
        .ocupado          (ocupado),
        .fin              (fin),
        .bus              (bus.master)
    );

    // RTC model: drives the read value only while rd_n is low.
    assign bus.ad_in = bus.rd_n ? 8'h00 : rd_val;

    always #5 CLK = ~CLK;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   fins = 0;
    int   viol = 0;
    int   cyc = 0;
    bit   held_mode = 0;
    bit   held_prev_vld = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Bus monitor and scoreboard consumer.
    initial begin
        int start, addr_cyc, wcyc, rcyc, oe, gap, last_fin;
        logic [7:0] addr_val, wval;
        bit addr_var, wvar, ocup_prev;
        exp_t e;
        start = 0; addr_cyc = 0; wcyc = 0; rcyc = 0; oe = 0; gap = 0; last_fin = 0;
        addr_val = 0; wval = 0; addr_var = 0; wvar = 0; ocup_prev = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!bus.rd_n && !bus.wr_n) viol++;
            if (bus.ad_oe && !bus.rd_n) viol++;
            if (reset) begin
                ocup_prev = 0;
            end else begin
                if (ocupado && !ocup_prev) begin
                    start = cyc; addr_cyc = 0; wcyc = 0; rcyc = 0; oe = 0; gap = 0;
                    addr_var = 0; wvar = 0;
                end
                ocup_prev = ocupado;
                if (ocupado) begin
                    if (!bus.cs_n && !bus.a_d && !bus.wr_n) begin
                        if (addr_cyc > 0 && bus.ad_out != addr_val) addr_var = 1;
                        addr_val = bus.ad_out;
                        addr_cyc++;
                    end
                    if (!bus.cs_n && bus.a_d && !bus.wr_n) begin
                        if (wcyc > 0 && bus.ad_out != wval) wvar = 1;
                        wval = bus.ad_out;
                        wcyc++;
                    end
                    if (!bus.cs_n && bus.a_d && !bus.rd_n) rcyc++;
                    if (bus.ad_oe) oe++;
                    if (bus.cs_n && !fin) gap++;
                end
                if (fin) begin
                    fins++;
                    if (held_mode) begin
                        if (held_prev_vld) check_eq("fin_period", cyc - last_fin, 14);
                        held_prev_vld = 1;
                    end
                    last_fin = cyc;
                    check_eq("fin_has_expect", (sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check_eq("latency", cyc - start, 2 * TP + 2 * TE);
                        check_eq("addr_cycles", addr_cyc, TP);
                        check_eq("addr_val", addr_val, e.addr);
                        check_eq("addr_stable", addr_var, 0);
                        check_eq("gap_cycles", gap, 2 * TE);
                        if (e.wr) begin
                            check_eq("wr_data_cycles", wcyc, TP);
                            check_eq("wr_data_val", wval, e.data);
                            check_eq("wr_data_stable", wvar, 0);
                            check_eq("wr_no_rd", rcyc, 0);
                            check_eq("wr_oe_cycles", oe, 2 * TP + 2);
                        end else begin
                            check_eq("rd_cycles", rcyc, TP);
                            check_eq("rd_no_wr_data", wcyc, 0);
                            check_eq("rd_data", dato_leido, e.data);
                            check_eq("rd_oe_cycles", oe, TP + 1);
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d,
                         input bit push);
        exp_t e;
        @(negedge CLK);
        Inicio_Escritura = w;
        Inicio_Lectura   = r;
        direccion        = a;
        dato_escribir    = d;
        if (push) begin
            e.wr = w; e.addr = a; e.data = w ? d : rd_val;
            sb.push_back(e);
        end
        @(negedge CLK);
        Inicio_Escritura = 1'b0;
        Inicio_Lectura   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && (sb.size() != 0 || ocupado); i++) @(negedge CLK);
        check_eq("done_in_time", {sb.size() != 0, ocupado}, 2'b00);
    endtask

    initial begin
        int f0;
        exp_t e;
        reset = 1'b1;
        Inicio_Escritura = 1'b0; Inicio_Lectura = 1'b0;
        direccion = 8'h00; dato_escribir = 8'h00; rd_val = 8'h00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_strobes", {bus.cs_n, bus.rd_n, bus.wr_n}, 3'b111);
        check_eq("rst_ctrl", {bus.a_d, bus.ad_oe, ocupado, fin}, 4'b0000);
        check_eq("rst_ad_out", bus.ad_out, 8'h00);
        check_eq("rst_leido", dato_leido, 8'h00);
        reset = 1'b0;

        // Plain write, then plain read.
        issue(1'b1, 1'b0, 8'h21, 8'h45, 1'b1);
        wait_done(40);
        rd_val = 8'h59;
        issue(1'b0, 1'b1, 8'h22, 8'h00, 1'b1);
        wait_done(40);
        rd_val = 8'h00;

        // Collision: write wins, read not queued.
        f0 = fins;
        issue(1'b1, 1'b1, 8'h23, 8'h77, 1'b1);
        wait_done(40);
        repeat (20) @(negedge CLK);
        check_eq("collision_fins", fins - f0, 1);
        check_eq("leido_stable", dato_leido, 8'h59);

        // Request during busy is dropped; address changes mid-cycle have no effect.
        f0 = fins;
        issue(1'b1, 1'b0, 8'h30, 8'hC3, 1'b1);
        repeat (4) @(negedge CLK);
        Inicio_Lectura = 1'b1; direccion = 8'hEE; dato_escribir = 8'h11;
        @(negedge CLK);
        Inicio_Lectura = 1'b0;
        wait_done(40);
        repeat (20) @(negedge CLK);
        check_eq("busy_fins", fins - f0, 1);

        // Reset during the data phase.
        f0 = fins;
        issue(1'b1, 1'b0, 8'h40, 8'hAA, 1'b0);
        for (int i = 0; i < 30 && !(bus.a_d && !bus.cs_n); i++) @(negedge CLK);
        check_eq("reached_dato", {bus.a_d, bus.cs_n}, 2'b10);
        reset = 1'b1;
        @(negedge CLK);
        check_eq("midrst_strobes", {bus.cs_n, bus.rd_n, bus.wr_n}, 3'b111);
        check_eq("midrst_ctrl", {bus.ad_oe, ocupado, fin}, 3'b000);
        reset = 1'b0;
        repeat (20) @(negedge CLK);
        check_eq("midrst_no_fin", fins - f0, 0);
        rd_val = 8'h3C;
        issue(1'b0, 1'b1, 8'h24, 8'h00, 1'b1);
        wait_done(40);
        repeat (3) @(negedge CLK);

        // Held read request: accepted at edges 0, 14, 28 of a 40-cycle hold.
        held_prev_vld = 0;
        held_mode = 1;
        Inicio_Lectura = 1'b1;
        direccion = 8'h25;
        for (int i = 0; i < 40; i++) begin
            if (i % 14 == 0) begin
                rd_val = 8'hA0 + 8'(i);
                e.wr = 1'b0; e.addr = 8'h25; e.data = rd_val;
                sb.push_back(e);
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        Inicio_Lectura = 1'b0;
        wait_done(40);
        repeat (20) @(negedge CLK);
        held_mode = 0;

        check_eq("total_fins", fins, 8);
        check_eq("strobe_rules", viol, 0);
        check_eq("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
